// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared constants for the load/store/fetch bus interface.
//               Holds the funct3 size codes, the fault-cause codes and the
//               access FSM state encodings, plus a funct3 legality helper.
// Revision    : 1.0  initial release
// ============================================================================
package mem_access_unit_pkg;

    // funct3 access-size codes (fetch reuses F3_W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // fault_cause codes
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // access FSM states
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;
    localparam logic [1:0] ST_ERR    = 2'b11;

    // Stores only have B/H/W; loads additionally have the unsigned forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic w_ok;
        w_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            w_ok = w_ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return w_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Purely combinational byte-lane logic for the memory access
//               unit. Request side: store strobe/data steering and legality
//               / misalignment flags. Response side: byte/half extraction and
//               sign/zero extension of the returned word.
// Ports       : i_we, i_addr_lo, i_funct3, i_wdata  - incoming request
//               o_wstrb, o_wdata                    - steered store lanes
//               o_illegal, o_misaligned             - request checks
//               i_ld_addr_lo, i_ld_funct3, i_rdata  - latched load + bus word
//               o_ld_data                           - extended load result
// Revision    : 1.0  initial release
// ============================================================================
module lsu_align
    import mem_access_unit_pkg::*;
(
    input  logic        i_we,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic        o_illegal,
    output logic        o_misaligned,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [2:0]  i_ld_funct3,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Request checks. funct3[1:0] gives the size for both signed and
    // unsigned forms, so misalignment only needs the low two bits.
    always_comb begin
        o_illegal    = !f3_legal(i_we, i_funct3);
        o_misaligned = 1'b0;
        if (i_funct3[1:0] == 2'b01) begin
            o_misaligned = i_addr_lo[0];
        end else if (i_funct3[1:0] == 2'b10) begin
            o_misaligned = (i_addr_lo != 2'b00);
        end
    end

    // Store steering: replicate the datum across the word so every lane
    // holds it, then let the strobes pick the live lane(s).
    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
        if (!i_we) begin
            o_wstrb = 4'b0000;
        end
    end

    // Load extraction from the latched offset.
    always_comb begin
        case (i_ld_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'd0, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store/fetch bus interface for the multicycle RV32I core.
//               Accepts a held request from the control FSM, checks it,
//               issues one word-aligned bus access with a ready/valid
//               wait-state handshake, formats load data and stalls the FSM
//               until the access completes or faults.
// Ports       : clk, rst (async, active low)
//               req_*        - request from control FSM
//               stall        - hold FSM state
//               rdata        - formatted load/fetch data (held)
//               fault        - one-cycle fault pulse, fault_cause held
//               mem_*        - external memory port
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdata;
    logic [1:0]        r_cause;

    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic              w_illegal;
    logic              w_misaligned;
    logic [31:0]       w_ld_data;
    logic              w_access;

    lsu_align u_align (
        .i_we         (req_we),
        .i_addr_lo    (req_addr[1:0]),
        .i_funct3     (req_funct3),
        .i_wdata      (req_wdata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_illegal    (w_illegal),
        .o_misaligned (w_misaligned),
        .i_ld_addr_lo (r_addr[1:0]),
        .i_ld_funct3  (r_funct3),
        .i_rdata      (mem_rdata),
        .o_ld_data    (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'b0000;
            r_cnt    <= '0;
            r_rdata  <= 32'd0;
            r_cause  <= CAUSE_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Illegal size takes priority: misalignment is only
                        // meaningful for a known access size.
                        if (w_illegal) begin
                            r_cause <= CAUSE_ILLEGAL;
                            r_state <= ST_ERR;
                        end else if (w_misaligned) begin
                            r_cause <= CAUSE_MISALIGN;
                            r_state <= ST_ERR;
                        end else begin
                            r_addr   <= req_addr;
                            r_we     <= req_we;
                            r_funct3 <= req_funct3;
                            r_wdata  <= w_wdata;
                            r_wstrb  <= w_wstrb;
                            r_cnt    <= '0;
                            r_state  <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        if (!r_we) begin
                            r_rdata <= w_ld_data;
                        end
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cause <= CAUSE_TIMEOUT;
                        r_state <= ST_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_access    = (r_state == ST_ACCESS);

    // rst gates the IDLE term so stall reads 0 while reset is asserted even
    // if the FSM is still presenting a request.
    assign stall       = rst && (((r_state == ST_IDLE) && req_valid) || w_access);
    assign fault       = (r_state == ST_ERR);
    assign fault_cause = r_cause;
    assign rdata       = r_rdata;
    assign mem_valid   = w_access;
    assign mem_we      = r_we && w_access;
    assign mem_addr    = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata   = r_wdata;
    assign mem_wstrb   = w_access ? r_wstrb : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit. The stimulus process
//               pushes the expected bus/fault response of each directed
//               request into a queue; a monitor pops and compares whenever
//               the DUT completes a handshake or raises a fault.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    typedef struct {
        bit          is_fault;
        logic [1:0]  cause;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   wait_n  = 0;
    int   vcnt    = 0;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_funct3  (req_funct3),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .fault       (fault),
        .fault_cause (fault_cause),
        .mem_valid   (mem_valid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Memory responder: ready after wait_n ACCESS cycles.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_valid) begin
                mem_ready = (vcnt == wait_n);
                vcnt++;
            end else begin
                mem_ready = 1'b0;
                vcnt = 0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t        e;
        bit          pend;
        logic [31:0] pend_rd;
        pend = 0;
        pend_rd = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 0;
                continue;
            end
            if (pend) begin
                chk("rdata", rdata, pend_rd);
                pend = 0;
            end
            if (mem_valid && mem_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_bus", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("bus_not_fault", {31'd0, e.is_fault}, 32'd0);
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    else begin
                        pend = 1;
                        pend_rd = e.rdata;
                    end
                end
            end
            if (fault) begin
                if (q.size() == 0) begin
                    chk("unexpected_fault", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("fault_expected", {31'd0, e.is_fault}, 32'd1);
                    chk("fault_cause", {30'd0, fault_cause}, {30'd0, e.cause});
                end
            end
        end
    end

    task automatic push(input bit f, input logic [1:0] c, input logic [31:0] a,
                        input bit w, input logic [3:0] s, input logic [31:0] d,
                        input logic [31:0] r);
        exp_t e;
        e.is_fault = f; e.cause = c; e.addr = a; e.we = w;
        e.wstrb = s; e.wdata = d; e.rdata = r;
        q.push_back(e);
    endtask

    // Drive one request, hold it while stalled, check stall/valid counts and
    // bus stability during wait states.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input int wn,
                         input int exp_stall, input int exp_valid, input bit is_fault);
        int          ns;
        int          nv;
        bit          done;
        bit          stable;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [1:0]  cause0;
        ns = 0; nv = 0; done = 0; stable = 1; a0 = 0; d0 = 0;
        mem_rdata = word;
        wait_n = wn;
        @(posedge clk);
        #2;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (mem_valid) begin
                nv++;
                if (nv == 1) begin a0 = mem_addr; d0 = mem_wdata; end
                else if (mem_addr !== a0 || mem_wdata !== d0) stable = 0;
            end
            if (stall) ns++;
            else begin done = 1; break; end
        end
        if (!done) chk("hang", 32'd0, 32'd1);
        chk("stall_cycles", ns, exp_stall);
        chk("valid_cycles", nv, exp_valid);
        if (nv > 1) chk("bus_stable", {31'd0, stable}, 32'd1);
        cause0 = fault_cause;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        if (is_fault) begin
            @(negedge clk);
            chk("fault_pulse", {31'd0, fault}, 32'd0);
            chk("cause_hold", {30'd0, fault_cause}, {30'd0, cause0});
        end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_funct3 = 3'b000; req_wdata = 32'd0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_fault", {29'd0, fault, fault_cause}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        @(posedge clk); #2; rst = 1'b1;

        // Loads
        push(0, 2'b00, 32'h100, 0, 4'b0000, 0, 32'hDEADBEEF);
        issue(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 2, 1, 0);
        push(0, 2'b00, 32'h100, 0, 4'b0000, 0, 32'hFFFFFF80);
        issue(0, 3'b000, 32'h103, 0, 32'h80112233, 0, 2, 1, 0);
        push(0, 2'b00, 32'h100, 0, 4'b0000, 0, 32'h00000080);
        issue(0, 3'b100, 32'h103, 0, 32'h80112233, 0, 2, 1, 0);
        push(0, 2'b00, 32'h100, 0, 4'b0000, 0, 32'h00008011);
        issue(0, 3'b101, 32'h102, 0, 32'h80112233, 0, 2, 1, 0);
        push(0, 2'b00, 32'h100, 0, 4'b0000, 0, 32'hFFFF8011);
        issue(0, 3'b001, 32'h102, 0, 32'h80112233, 0, 2, 1, 0);
        push(0, 2'b00, 32'h100, 0, 4'b0000, 0, 32'h00000033);
        issue(0, 3'b000, 32'h100, 0, 32'h80112233, 0, 2, 1, 0);

        // Stores (bus word is junk: rdata must not change)
        push(0, 2'b00, 32'h200, 1, 4'b0010, 32'hABABABAB, 0);
        issue(1, 3'b000, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 0, 2, 1, 0);
        chk("store_keeps_rdata", rdata, 32'h00000033);
        push(0, 2'b00, 32'h200, 1, 4'b1100, 32'h12341234, 0);
        issue(1, 3'b001, 32'h202, 32'h00001234, 32'hFFFFFFFF, 0, 2, 1, 0);
        // Store with 5 wait states
        push(0, 2'b00, 32'h300, 1, 4'b1111, 32'hCAFEF00D, 0);
        issue(1, 3'b010, 32'h300, 32'hCAFEF00D, 32'hFFFFFFFF, 5, 7, 6, 0);

        // Faults: no bus cycle, one-cycle pulse
        push(1, 2'b01, 0, 0, 0, 0, 0);
        issue(0, 3'b010, 32'h102, 0, 0, 0, 1, 0, 1);
        push(1, 2'b10, 0, 0, 0, 0, 0);
        issue(1, 3'b011, 32'h400, 32'h11, 0, 0, 1, 0, 1);
        push(1, 2'b10, 0, 0, 0, 0, 0);
        issue(0, 3'b110, 32'h400, 0, 0, 0, 1, 0, 1);
        push(1, 2'b01, 0, 0, 0, 0, 0);
        issue(1, 3'b001, 32'h201, 32'h5555, 0, 0, 1, 0, 1);

        // Timeout: 16 ACCESS cycles then cause 11
        push(1, 2'b11, 0, 0, 0, 0, 0);
        issue(0, 3'b010, 32'h500, 0, 0, 1000, 17, 16, 1);

        // Reset mid-ACCESS: bus drops at once, nothing completes
        wait_n = 1000;
        @(posedge clk); #2;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h600; req_wdata = 32'h77777777;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
        #2; rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, mem_valid}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_bus", {mem_we, mem_wstrb}, 32'd0);
        chk("midrst_addr", mem_addr, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_fault", {29'd0, fault, fault_cause}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #2; rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {30'd0, mem_valid, stall}, 32'd0);
        chk("queue_empty", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store/fetch bus interface for the multicycle RV32I core.
- Sits directly downstream of the main control FSM's memory-control outputs (fetch, memory read, memory write) and upstream of the external memory port.
- Performs byte-lane steering, load sign/zero extension, misalignment checking and a ready/valid wait-state handshake.
- Returns a stall to the control FSM until the access completes.

Parameters:
- ADDR_W, 32, address width
- TIMEOUT, 16, max ACCESS cycles without mem_ready before bus error (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  access requested this cycle (level, held by FSM while stall=1)
- req_we  in  1  1=store, 0=load/fetch
- req_addr  in  ADDR_W  byte address (PC or ALU result, already muxed by AdrSrc)
- req_funct3  in  3  access size/sign; fetch drives 3'b010
- req_wdata  in  32  store data (rs2)
- stall  out  1  FSM must hold state
- rdata  out  32  extended load/fetch data, held until next completed load
- fault  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- fault_cause  out  2  00 none, 01 misaligned, 10 illegal size, 11 timeout
- mem_valid  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-steered store data
- mem_wstrb  out  4  byte enables (0000 on reads)
- mem_ready  in  1  bus completes when mem_valid&mem_ready
- mem_rdata  in  32  word read data, valid with mem_ready

Behaviour:
- Reset (async, rst=0): state=IDLE; all outputs 0; rdata=0; timeout counter=0. A reset mid-ACCESS drops mem_valid immediately with no completion.
- States: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - No req_valid: stall=0.
  - req_valid with a legal, aligned access: latch addr/we/funct3/steered data/strobes; stall=1; go ACCESS.
  - req_valid with an illegal or misaligned access: stall=1; go ERR. No bus cycle is issued.
- ACCESS:
  - mem_valid=1; stall=1; mem_* outputs come from registers and stay stable until handshake.
  - On mem_ready: capture formatted rdata (loads only; stores leave rdata unchanged); go DONE.
  - Otherwise increment counter. At counter==TIMEOUT-1 without mem_ready: go ERR with cause 11.
- DONE:
  - stall=0; mem_valid=0; go IDLE unconditionally.
  - req_valid in DONE belongs to the finishing request and is ignored.
- ERR:
  - fault=1 with latched cause; stall=0; go IDLE.
  - fault_cause holds its value until the next fault; fault is a pulse.
- Minimum latency: accept at cycle N, mem_valid at N+1, ready at N+1 -> DONE at N+2. stall is high for exactly 2 cycles.
- Legality:
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others are illegal.
  - Stores: 000 SB, 001 SH, 010 SW; others are illegal.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Store steering:
  - SB: wstrb=0001<<addr[1:0], wdata={4{b}}.
  - SH: wstrb=0011 (addr[1]=0) or 1100; wdata={2{h}}.
  - SW: wstrb=1111.
- Load extraction:
  - Select byte/half at addr[1:0] from mem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Counter clears on entry to ACCESS.

Decomposition:
- Shared defines header (alongside the existing OP_* defines): F3_B/H/W/BU/HU constants, fault-cause codes, state encodings.
- One combinational sub-module, lsu_align: computes wstrb/wdata steering, load extraction/extension, and legality/misalignment flags from addr[1:0], funct3 and we.
- The FSM, registers and counter stay in mem_access_unit.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, ready in first ACCESS cycle -> mem_addr=0x100, wstrb=0000, stall high 2 cycles, rdata=0xDEADBEEF.
- LB addr 0x103, mem_rdata 0x80112233 -> rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
- SB addr 0x201 wdata 0x000000AB -> mem_addr=0x200, wstrb=0010, mem_wdata=0xABABABAB, mem_we=1; SH addr 0x202 -> wstrb=1100.
- LW addr 0x102 -> no mem_valid, fault pulse 1 cycle, cause=01; store funct3=011 -> cause=10.
- mem_ready held 0 with TIMEOUT=16 -> mem_valid for 16 cycles, then fault with cause=11, stall=0, returns to IDLE.
- Wait states: ready after 5 cycles -> mem_addr/wdata stable throughout. Separately, rst=0 during ACCESS -> mem_valid drops same cycle, all outputs 0, no fault.
